// File: rtl/input_port_unit.sv
// Mesh router input port: flit FIFO on a req/ack link, XY route
// computation on head flits, allocator request and crossbar drive.
module input_port_unit #(
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_in,
    input  logic [17:0] data_in,
    output logic        ack_in,
    output logic        req_port,
    output logic [2:0]  rout_port,
    input  logic        grant,
    output logic        req_out,
    output logic [17:0] data_out,
    input  logic        ack_out,
    output logic        proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] RX = 2'(ROUTER_X);
    localparam logic [1:0] RY = 2'(ROUTER_Y);

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          err_set;
    logic          latch_route;
    logic [17:0]   head;
    logic [1:0]    dx;
    logic [1:0]    dy;
    logic [2:0]    route;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign dx       = head[15:14];
    assign dy       = head[13:12];
    assign data_out = empty ? '0 : head;
    // ack_in high blocks the write so a held req_in is not captured twice
    assign push     = req_in && !full && !ack_in;
    assign req_port = (state != IDLE);

    always_comb begin
        route = 3'd0;
        if (dx > RX)
            route = 3'd3;
        else if (dx < RX)
            route = 3'd1;
        else if (dy > RY)
            route = 3'd4;
        else if (dy < RY)
            route = 3'd2;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        err_set     = 1'b0;
        latch_route = 1'b0;
        req_out     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head[16]) begin
                        state_nxt   = REQ;
                        latch_route = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        err_set = 1'b1;
                    end
                end
            end
            REQ: begin
                if (grant)
                    state_nxt = SEND;
            end
            SEND: begin
                req_out = !empty && grant;
                pop     = req_out && ack_out;
                if (pop && head[17])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ack_in    <= 1'b0;
            rout_port <= 3'd0;
            proto_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            ack_in <= push;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (latch_route)
                rout_port <= route;
            if (err_set)
                proto_err <= 1'b1;
        end
    end

endmodule
